// File: rtl/uart_core_if.sv
// uart_core_if: memory-stage register window of the UART (transmit strobe, receive status).
interface uart_core_if;
    logic [7:0] tx_data;
    logic       tx_we;
    logic       tx_busy;
    logic       rx_re;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_overrun;
    logic       rx_frame_err;
    modport master (
        output tx_data, tx_we, rx_re,
        input  tx_busy, rx_data, rx_valid, rx_overrun, rx_frame_err
    );
    modport slave (
        input  tx_data, tx_we, rx_re,
        output tx_busy, rx_data, rx_valid, rx_overrun, rx_frame_err
    );
endinterface

// File: rtl/uart_core.sv
// uart_core: 8N1 UART with a small transmit FIFO and a one-byte receive register.
module uart_core #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int BAUD     = 115200,
    parameter int TX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    uart_core_if.slave  bus,
    output logic        uart_txd,
    input  logic        uart_rxd
);
    localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW = $clog2(DIV + 1);
    localparam int AW = $clog2(TX_DEPTH);
    localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] ONE = CW'(1);
    localparam logic [AW:0] DEPTH_V = (AW + 1)'(TX_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]  mem [TX_DEPTH];
    logic [AW:0] wp, rp, wp_n, rp_n;
    logic        push, pop, empty;

    assign empty = (wp == rp);
    assign push  = bus.tx_we && ((wp - rp) != DEPTH_V);
    assign wp_n  = wp + {{AW{1'b0}}, push};
    assign rp_n  = rp + {{AW{1'b0}}, pop};

    always_ff @(posedge clk)
        if (push) mem[wp[AW-1:0]] <= bus.tx_data;

    state_t        ts, ts_n;
    logic [CW-1:0] tc, tc_n;
    logic [2:0]    tb, tb_n;
    logic [7:0]    tsh, tsh_n;

    always_comb begin
        ts_n  = ts;
        tc_n  = tc - ONE;
        tb_n  = tb;
        tsh_n = tsh;
        pop   = 1'b0;
        case (ts)
            IDLE: begin
                tc_n = DIV_M1;
                if (!empty) begin
                    pop   = 1'b1;
                    tsh_n = mem[rp[AW-1:0]];
                    ts_n  = START;
                end
            end
            START: if (tc == '0) begin
                ts_n = DATA;
                tc_n = DIV_M1;
                tb_n = 3'd0;
            end
            DATA: if (tc == '0) begin
                tc_n  = DIV_M1;
                tsh_n = tsh >> 1;
                tb_n  = tb + 3'd1;
                ts_n  = (tb == 3'd7) ? STOP : DATA;
            end
            STOP: if (tc == '0) ts_n = IDLE;
            default: ts_n = IDLE;
        endcase
    end

    // The line level is registered from the state, so it trails the FSM by one clock.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            ts          <= IDLE;
            tc          <= '0;
            tb          <= '0;
            tsh         <= '0;
            wp          <= '0;
            rp          <= '0;
            bus.tx_busy <= 1'b0;
            uart_txd    <= 1'b1;
        end else begin
            ts          <= ts_n;
            tc          <= tc_n;
            tb          <= tb_n;
            tsh         <= tsh_n;
            wp          <= wp_n;
            rp          <= rp_n;
            bus.tx_busy <= (wp_n - rp_n) == DEPTH_V;
            uart_txd    <= (ts == START) ? 1'b0 : (ts == DATA) ? tsh[0] : 1'b1;
        end

    logic          s1, s2;
    state_t        rs, rs_n;
    logic [CW-1:0] rc, rc_n;
    logic [2:0]    rb, rb_n;
    logic [7:0]    rsh, rsh_n;
    logic          done, load, ovr, ferr;

    always_comb begin
        rs_n  = rs;
        rc_n  = rc - ONE;
        rb_n  = rb;
        rsh_n = rsh;
        done  = 1'b0;
        case (rs)
            IDLE: begin
                rc_n = HALF_M1;
                if (!s2) rs_n = START;
            end
            START: if (rc == '0) begin
                rs_n = s2 ? IDLE : DATA;
                rc_n = DIV_M1;
                rb_n = 3'd0;
            end
            DATA: if (rc == '0) begin
                rc_n  = DIV_M1;
                rsh_n = {s2, rsh[7:1]};
                rb_n  = rb + 3'd1;
                rs_n  = (rb == 3'd7) ? STOP : DATA;
            end
            STOP: if (rc == '0) begin
                done = 1'b1;
                rs_n = IDLE;
            end
            default: rs_n = IDLE;
        endcase
    end

    // A read in the completion cycle frees the register, so the new byte loads instead of overrunning.
    assign load = done && s2 && (!bus.rx_valid || bus.rx_re);
    assign ovr  = done && s2 && bus.rx_valid && !bus.rx_re;
    assign ferr = done && !s2;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            s1               <= 1'b1;
            s2               <= 1'b1;
            rs               <= IDLE;
            rc               <= '0;
            rb               <= '0;
            rsh              <= '0;
            bus.rx_data      <= '0;
            bus.rx_valid     <= 1'b0;
            bus.rx_overrun   <= 1'b0;
            bus.rx_frame_err <= 1'b0;
        end else begin
            s1               <= uart_rxd;
            s2               <= s1;
            rs               <= rs_n;
            rc               <= rc_n;
            rb               <= rb_n;
            rsh              <= rsh_n;
            bus.rx_data      <= load ? rsh : bus.rx_data;
            bus.rx_valid     <= load ? 1'b1 : bus.rx_re ? 1'b0 : bus.rx_valid;
            bus.rx_overrun   <= ovr ? 1'b1 : bus.rx_re ? 1'b0 : bus.rx_overrun;
            bus.rx_frame_err <= ferr ? 1'b1 : bus.rx_re ? 1'b0 : bus.rx_frame_err;
        end
endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: directed checks of uart_core at DIV=10, HALF=5.
module tb_uart_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd = 1'b1;
    logic txd;
    int   n_cmp = 0;
    int   n_bad = 0;

    uart_core_if bus();

    uart_core #(.CLK_HZ(1000), .BAUD(100), .TX_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .bus(bus), .uart_txd(txd), .uart_rxd(rxd)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one 100-clock frame; rx_re is pulsed on iteration re_at (-1 for never).
    task automatic send(input logic [7:0] b, input logic stop_v, input int re_at);
        logic [9:0] fr;
        fr = {stop_v, b, 1'b0};
        for (int t = 0; t < 100; t++) begin
            rxd = fr[t / 10];
            bus.rx_re = (t == re_at);
            tick();
        end
        rxd = 1'b1;
        bus.rx_re = 1'b0;
    endtask

    task automatic test_reset();
        bus.tx_data = 8'h00;
        bus.tx_we = 1'b0;
        bus.rx_re = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({txd, bus.tx_busy, bus.rx_valid, bus.rx_overrun, bus.rx_frame_err} !== 5'b10000) begin
            n_bad++;
            $display("FAIL reset_status got=%b want=10000", {txd, bus.tx_busy, bus.rx_valid, bus.rx_overrun, bus.rx_frame_err});
        end
        n_cmp++;
        if (bus.rx_data !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_rx_data got=%h want=00", bus.rx_data);
        end
        rst = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_tx_single();
        logic [10:0] fr;
        fr = {2'b11, 8'hA5, 1'b0};
        bus.tx_data = 8'hA5;
        bus.tx_we = 1'b1;
        tick();
        bus.tx_we = 1'b0;
        n_cmp++;
        if (bus.tx_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL single_busy got=%b want=0", bus.tx_busy);
        end
        tick();
        n_cmp++;
        if (txd !== 1'b1) begin
            n_bad++;
            $display("FAIL single_pop_line got=%b want=1", txd);
        end
        for (int k = 0; k <= 100; k++) begin
            tick();
            n_cmp++;
            if (txd !== fr[k / 10]) begin
                n_bad++;
                $display("FAIL single_bit k=%0d got=%b want=%b", k, txd, fr[k / 10]);
            end
        end
    endtask

    task automatic test_tx_fifo();
        logic [7:0]  exp_b [5];
        logic [10:0] fr;
        exp_b = '{8'hFF, 8'h01, 8'h02, 8'h03, 8'h04};
        bus.tx_data = 8'hFF;
        bus.tx_we = 1'b1;
        tick();
        bus.tx_we = 1'b0;
        tick();
        for (int i = 1; i <= 5; i++) begin
            bus.tx_data = 8'(i);
            bus.tx_we = 1'b1;
            tick();
            n_cmp++;
            if (bus.tx_busy !== (i >= 4)) begin
                n_bad++;
                $display("FAIL fifo_busy write=%0d got=%b want=%b", i, bus.tx_busy, (i >= 4));
            end
            n_cmp++;
            if (txd !== 1'b0) begin
                n_bad++;
                $display("FAIL fifo_start_bit write=%0d got=%b want=0", i, txd);
            end
        end
        bus.tx_we = 1'b0;
        for (int j = 0; j < 5; j++) begin
            fr = {2'b11, exp_b[j], 1'b0};
            for (int k = 0; k <= 100; k++) begin
                if (j == 0 && k < 5) continue;
                tick();
                n_cmp++;
                if (txd !== fr[k / 10]) begin
                    n_bad++;
                    $display("FAIL fifo_frame%0d_bit k=%0d got=%b want=%b", j, k, txd, fr[k / 10]);
                end
            end
        end
        n_cmp++;
        if (bus.tx_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL fifo_drained_busy got=%b want=0", bus.tx_busy);
        end
        for (int k = 0; k < 30; k++) begin
            tick();
            n_cmp++;
            if (txd !== 1'b1) begin
                n_bad++;
                $display("FAIL fifo_dropped_byte k=%0d got=%b want=1", k, txd);
            end
        end
    endtask

    task automatic test_rx_overrun();
        send(8'h3C, 1'b1, -1);
        repeat (5) tick();
        n_cmp++;
        if ({bus.rx_valid, bus.rx_overrun, bus.rx_frame_err, bus.rx_data} !== {3'b100, 8'h3C}) begin
            n_bad++;
            $display("FAIL rx_first got v/o/f/d=%b%b%b/%h want 100/3c", bus.rx_valid, bus.rx_overrun, bus.rx_frame_err, bus.rx_data);
        end
        send(8'h77, 1'b1, -1);
        repeat (5) tick();
        n_cmp++;
        if ({bus.rx_valid, bus.rx_overrun, bus.rx_data} !== {2'b11, 8'h3C}) begin
            n_bad++;
            $display("FAIL rx_overrun got v/o/d=%b%b/%h want 11/3c", bus.rx_valid, bus.rx_overrun, bus.rx_data);
        end
        bus.rx_re = 1'b1;
        tick();
        bus.rx_re = 1'b0;
        n_cmp++;
        if ({bus.rx_valid, bus.rx_overrun, bus.rx_frame_err} !== 3'b000) begin
            n_bad++;
            $display("FAIL rx_read_clear got=%b want=000", {bus.rx_valid, bus.rx_overrun, bus.rx_frame_err});
        end
    endtask

    task automatic test_rx_edge();
        rxd = 1'b0;
        repeat (3) tick();
        rxd = 1'b1;
        repeat (20) tick();
        n_cmp++;
        if ({bus.rx_valid, bus.rx_overrun, bus.rx_frame_err} !== 3'b000) begin
            n_bad++;
            $display("FAIL rx_glitch got=%b want=000", {bus.rx_valid, bus.rx_overrun, bus.rx_frame_err});
        end
        send(8'h55, 1'b0, -1);
        repeat (20) tick();
        n_cmp++;
        if ({bus.rx_valid, bus.rx_frame_err} !== 2'b01) begin
            n_bad++;
            $display("FAIL rx_frame_err got v/f=%b%b want 01", bus.rx_valid, bus.rx_frame_err);
        end
        bus.rx_re = 1'b1;
        tick();
        bus.rx_re = 1'b0;
        n_cmp++;
        if (bus.rx_frame_err !== 1'b0) begin
            n_bad++;
            $display("FAIL rx_frame_err_clear got=%b want=0", bus.rx_frame_err);
        end
        send(8'h5A, 1'b1, -1);
        repeat (5) tick();
        n_cmp++;
        if ({bus.rx_valid, bus.rx_frame_err, bus.rx_data} !== {2'b10, 8'h5A}) begin
            n_bad++;
            $display("FAIL rx_recover got v/f/d=%b%b/%h want 10/5a", bus.rx_valid, bus.rx_frame_err, bus.rx_data);
        end
    endtask

    task automatic test_simultaneous();
        send(8'h81, 1'b1, 97);
        repeat (3) tick();
        n_cmp++;
        if ({bus.rx_valid, bus.rx_overrun, bus.rx_data} !== {2'b10, 8'h81}) begin
            n_bad++;
            $display("FAIL rx_same_cycle got v/o/d=%b%b/%h want 10/81", bus.rx_valid, bus.rx_overrun, bus.rx_data);
        end
    endtask

    task automatic test_reset_midframe();
        bus.tx_data = 8'h00;
        bus.tx_we = 1'b1;
        tick();
        bus.tx_data = 8'h11;
        tick();
        bus.tx_we = 1'b0;
        repeat (15) tick();
        n_cmp++;
        if (txd !== 1'b0) begin
            n_bad++;
            $display("FAIL midframe_line got=%b want=0", txd);
        end
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if (txd !== 1'b1) begin
            n_bad++;
            $display("FAIL async_reset_txd got=%b want=1", txd);
        end
        n_cmp++;
        if ({bus.tx_busy, bus.rx_valid, bus.rx_overrun, bus.rx_frame_err, bus.rx_data} !== 12'h000) begin
            n_bad++;
            $display("FAIL async_reset_status got=%h want=000", {bus.tx_busy, bus.rx_valid, bus.rx_overrun, bus.rx_frame_err, bus.rx_data});
        end
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 120; k++) begin
            tick();
            n_cmp++;
            if (txd !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_fifo_empty k=%0d got=%b want=1", k, txd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_tx_single();
        test_tx_fifo();
        test_rx_overrun();
        test_rx_edge();
        test_simultaneous();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
